// File: rtl/machine_arbiter.sv
// Round-robin arbiter sharing one fixed-latency Machine_topEntity datapath between NREQ requesters.
// Issued operands are tagged with the requester id so each result can be routed back.
module machine_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned LATENCY = 2
) (
    input  logic                      system1000,
    input  logic                      system1000_rstn,
    input  logic [NREQ-1:0]           cfg_enable,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [8*NREQ-1:0]         req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic [7:0]                m_x,
    input  logic [11:0]               m_result,
    output logic                      resp_valid,
    output logic [$clog2(NREQ)-1:0]   resp_id,
    output logic [11:0]               resp_data,
    output logic [15:0]               issue_count
);

    localparam int unsigned IDW   = $clog2(NREQ);
    localparam int unsigned DEPTH = LATENCY + 1;

    logic [NREQ-1:0] eligible;
    logic            gnt_found;
    logic [IDW-1:0]  gnt_idx;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  ptr_nxt;
    logic [7:0]      gnt_data;
    logic            xfer;

    logic            tag_v  [DEPTH];
    logic [IDW-1:0]  tag_id [DEPTH];

    assign eligible = req_valid & cfg_enable;

    // First eligible index at or above ptr, wrapping modulo NREQ.
    always_comb begin
        int unsigned idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!gnt_found && eligible[IDW'(idx)]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(idx);
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                gnt_data = req_data[8*i +: 8];
            end
        end
    end

    assign ptr_nxt   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
    assign xfer      = gnt_found & system1000_rstn;
    assign req_ready = xfer ? (NREQ'(1) << gnt_idx) : '0;

    // Issue side: operand register, pointer, counter and the tag pipeline that tracks the datapath.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            ptr         <= '0;
            m_x         <= '0;
            issue_count <= '0;
            resp_valid  <= 1'b0;
            resp_id     <= '0;
            resp_data   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tag_v[i]  <= 1'b0;
                tag_id[i] <= '0;
            end
        end else begin
            if (xfer) begin
                ptr         <= ptr_nxt;
                m_x         <= gnt_data;
                issue_count <= issue_count + 16'd1;
            end
            tag_v[0]  <= xfer;
            tag_id[0] <= gnt_idx;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
            // The oldest tag lines up with the datapath output on this edge.
            resp_valid <= tag_v[LATENCY];
            if (tag_v[LATENCY]) begin
                resp_id   <= tag_id[LATENCY];
                resp_data <= m_result;
            end
        end
    end

endmodule

// File: tb/tb_machine_arbiter.sv
// Directed bench for machine_arbiter: vector table plus reset and counter-wrap sequences,
// with a behavioural two-stage datapath standing in for Machine_topEntity.
module tb_machine_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned LAT  = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  cfg_enable;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [7:0]  m_x;
    logic [11:0] m_result;
    logic        resp_valid;
    logic [1:0]  resp_id;
    logic [11:0] resp_data;
    logic [15:0] issue_count;

    always #5 clk = ~clk;

    machine_arbiter #(.NREQ(NREQ), .LATENCY(LAT)) dut (
        .system1000      (clk),
        .system1000_rstn (rstn),
        .cfg_enable      (cfg_enable),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .m_x             (m_x),
        .m_result        (m_result),
        .resp_valid      (resp_valid),
        .resp_id         (resp_id),
        .resp_data       (resp_data),
        .issue_count     (issue_count)
    );

    function automatic logic [11:0] dp_fn(input logic [7:0] x);
        return {x[3:0], x} ^ 12'h5A3;
    endfunction

    // Datapath model: result of m_x appears LAT cycles after m_x changes.
    logic [11:0] p0 = '0;
    logic [11:0] p1 = '0;
    always @(posedge clk) begin
        p0 <= dp_fn(m_x);
        p1 <= p0;
    end
    assign m_result = p1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic        sv  [64];
    logic [1:0]  sid [64];
    logic [11:0] sd  [64];
    logic [7:0]  exp_mx;
    logic [15:0] exp_cnt;
    logic [1:0]  exp_rid;
    logic [11:0] exp_rd;

    typedef struct {
        logic [3:0]  en;
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  ready;
    } vec_t;

    vec_t vecs [26];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) sv[i] = 1'b0;
        exp_mx  = '0;
        exp_cnt = '0;
        exp_rid = '0;
        exp_rd  = '0;
    endtask

    // Apply one cycle of inputs just after a falling edge, then check on the next falling edge.
    task automatic step(input logic [3:0] en, input logic [3:0] v,
                        input logic [31:0] d, input logic [3:0] er);
        int g;
        int slot;
        logic [7:0] op;
        cfg_enable = en;
        req_valid  = v;
        req_data   = d;
        #1;
        chk("req_ready", 32'(req_ready), 32'(er));
        if (er != 4'b0) begin
            g = 0;
            for (int i = 0; i < 4; i++) if (er[i]) g = i;
            op        = d[8*g +: 8];
            slot      = (cyc + 2 + int'(LAT)) % 64;
            sv[slot]  = 1'b1;
            sid[slot] = 2'(g);
            sd[slot]  = dp_fn(op);
            exp_mx    = op;
            exp_cnt   = exp_cnt + 16'd1;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        slot = cyc % 64;
        chk("m_x", 32'(m_x), 32'(exp_mx));
        chk("issue_count", 32'(issue_count), 32'(exp_cnt));
        chk("resp_valid", 32'(resp_valid), 32'(sv[slot]));
        if (sv[slot]) begin
            exp_rid = sid[slot];
            exp_rd  = sd[slot];
        end
        chk("resp_id", 32'(resp_id), 32'(exp_rid));
        chk("resp_data", 32'(resp_data), 32'(exp_rd));
        sv[slot] = 1'b0;
    endtask

    // Short reset pulse inside one clock low phase; outputs must clear immediately.
    task automatic rst_pulse();
        req_valid  = 4'b0;
        cfg_enable = 4'hF;
        #2 rstn = 1'b0;
        #1;
        chk("rst m_x", 32'(m_x), 32'h0);
        chk("rst resp_valid", 32'(resp_valid), 32'h0);
        chk("rst resp_id", 32'(resp_id), 32'h0);
        chk("rst resp_data", 32'(resp_data), 32'h0);
        chk("rst issue_count", 32'(issue_count), 32'h0);
        req_valid = 4'hF;
        #1;
        chk("rst req_ready", 32'(req_ready), 32'h0);
        req_valid = 4'b0;
        rstn      = 1'b1;
        model_clear();
        @(negedge clk);
    endtask

    initial begin
        rstn       = 1'b0;
        cfg_enable = 4'hF;
        req_valid  = 4'hF;
        req_data   = '0;
        model_clear();

        vecs[0]  = '{4'hF, 4'hF, 32'h44332211, 4'b0001};
        vecs[1]  = '{4'hF, 4'hF, 32'h44332211, 4'b0010};
        vecs[2]  = '{4'hF, 4'hF, 32'h44332211, 4'b0100};
        vecs[3]  = '{4'hF, 4'hF, 32'h44332211, 4'b1000};
        vecs[4]  = '{4'hF, 4'hF, 32'h88776655, 4'b0001};
        vecs[5]  = '{4'hF, 4'hF, 32'h88776655, 4'b0010};
        vecs[6]  = '{4'hF, 4'hF, 32'h88776655, 4'b0100};
        vecs[7]  = '{4'hF, 4'hF, 32'h88776655, 4'b1000};
        vecs[8]  = '{4'hF, 4'b0100, 32'h00350000, 4'b0100};
        for (int i = 9; i < 14; i++) vecs[i] = '{4'hF, 4'b0, 32'h0, 4'b0};
        vecs[14] = '{4'hA, 4'hF, 32'hDDCCBBAA, 4'b1000};
        vecs[15] = '{4'hA, 4'hF, 32'hDDCCBBAA, 4'b0010};
        vecs[16] = '{4'hA, 4'hF, 32'hD1CCB1AA, 4'b1000};
        vecs[17] = '{4'hA, 4'hF, 32'hD2CCB2AA, 4'b0010};
        vecs[18] = '{4'hF, 4'b0010, 32'h00005E00, 4'b0010};
        vecs[19] = '{4'hF, 4'b0000, 32'h0, 4'b0};
        vecs[20] = '{4'hF, 4'b1000, 32'h71000000, 4'b1000};
        for (int i = 21; i < 26; i++) vecs[i] = '{4'hF, 4'b0, 32'h0, 4'b0};

        #3;
        chk("init m_x", 32'(m_x), 32'h0);
        chk("init resp_valid", 32'(resp_valid), 32'h0);
        chk("init issue_count", 32'(issue_count), 32'h0);
        chk("init req_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 26; i++) begin
            step(vecs[i].en, vecs[i].valid, vecs[i].data, vecs[i].ready);
        end

        // Three operands in flight, then reset before any result returns.
        step(4'hF, 4'hF, 32'h0C0B0A09, 4'b0001);
        step(4'hF, 4'hF, 32'h0C0B0A09, 4'b0010);
        step(4'hF, 4'hF, 32'h0C0B0A09, 4'b0100);
        rst_pulse();
        for (int i = 0; i < 6; i++) step(4'hF, 4'b0, 32'h0, 4'b0);
        step(4'hF, 4'hF, 32'h13121110, 4'b0001);
        for (int i = 0; i < 5; i++) step(4'hF, 4'b0, 32'h0, 4'b0);

        // Issue counter wrap after 65536 transfers.
        rst_pulse();
        cfg_enable = 4'hF;
        req_valid  = 4'hF;
        repeat (65535) @(posedge clk);
        @(negedge clk);
        chk("issue_count ffff", 32'(issue_count), 32'h0000FFFF);
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'b0;
        chk("issue_count wrap", 32'(issue_count), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/machine_arbiter.md
# machine_arbiter

Shares one `Machine_topEntity` datapath (8-bit `x` in, 12-bit `result` out, fixed pipeline latency) between `NREQ` requesters on the `system1000` domain. The arbiter grants one request per cycle in round-robin order, drives the datapath input, and tags every issued operand. When the result emerges, the tag routes it back to the originating requester. It sits between the requester fabric and `Machine_topEntity`, which it instantiates externally through the `m_x` / `m_result` ports.

## Interface

Parameters:
- `NREQ`, 4, number of requesters (2..8).
- `LATENCY`, 2, cycles from `m_x` change to the matching `m_result` (≥ 0).

Ports:
- `system1000`  in  1  clock, rising edge.
- `system1000_rstn`  in  1  asynchronous, active-low reset.
- `cfg_enable`  in  NREQ  per-requester enable mask. A 0 bit means that requester is never granted.
- `req_valid`  in  NREQ  request valid, one bit per requester.
- `req_data`  in  8*NREQ  operand for requester i, at bits `[8i+7:8i]`.
- `req_ready`  out  NREQ  one-hot grant. At most one bit is set.
- `m_x`  out  8  registered operand driven to the datapath `x`.
- `m_result`  in  12  datapath `result`.
- `resp_valid`  out  1  registered result strobe, one cycle per issued operand.
- `resp_id`  out  log2(NREQ) (min 1)  requester index of the result.
- `resp_data`  out  12  result value.
- `issue_count`  out  16  total accepted operands since reset. Wraps 0xFFFF→0.

## Operation

- Eligible set: `req_valid & cfg_enable`.
- Round-robin pointer `ptr`, reset value 0.
  - The search starts at `ptr` and goes upward modulo NREQ.
  - The first eligible index g is granted, and `req_ready[g]` is set combinationally in the same cycle.
- Handshake: a transfer occurs when `req_valid[g] & req_ready[g]`. The requester must hold `req_data` stable while `req_valid` is high and it has not been granted. The arbiter never deasserts grant to a valid, enabled requester without a transfer.
- On a transfer from g, at the next edge:
  - `m_x` ← `req_data[g]`
  - `ptr` ← (g+1) mod NREQ
  - `issue_count` ← +1
  - a tag {valid=1, id=g} is pushed into the tag shift register.
- If nothing is eligible: no grant, `ptr` unchanged, `m_x` holds its last value, and a tag {valid=0} is pushed.
- Tag shift register depth is `LATENCY`+1, advanced every cycle; it has no stall. The tag leaving the register is paired with `m_result` sampled on that same edge:
  - `resp_valid` ← tag.valid.
  - `resp_id` and `resp_data` load only when tag.valid = 1, and hold otherwise.
- `resp` has no backpressure. Consumers must accept one result per cycle.
- A `cfg_enable` change affects only future grants. In-flight tags still complete.
- A requester dropping `req_valid` before being granted is legal. It is simply skipped.
- Reset (asynchronous, any time):
  - `m_x`=0, `resp_valid`=0, `resp_id`=0, `resp_data`=0, `issue_count`=0, `ptr`=0.
  - All tags are cleared, so in-flight operations are discarded and produce no `resp`.
  - `req_ready`=0 while `system1000_rstn`=0.
- Width rules: `issue_count` is unsigned modulo 2^16. `resp_data` is `m_result` unmodified (12 bits). `m_x` is the operand unmodified (8 bits).

## Timing

- Grant latency: 0 cycles. `req_ready` is a combinational function of `req_valid`, `cfg_enable` and `ptr`.
- Throughput: 1 operand per cycle sustained, with any mix of requesters.
- Latency example: a transfer on the edge ending cycle t puts `m_x` valid during cycle t+1. `resp_valid` is then high during cycle t+2+LATENCY, i.e. 4 cycles after the handshake cycle at LATENCY=2.
- Results return in issue order. Back-to-back issues give back-to-back `resp_valid` pulses.
- Fairness: with all NREQ continuously eligible, each requester is granted exactly once per NREQ cycles.
- Reset release: the first grant is possible in the first cycle after `system1000_rstn` rises, starting from index 0.

## Test plan

- Single request: only requester 2 holds `req_data`=0x35 for one handshake. Required: `req_ready`=0b0100 in that cycle, `m_x`=0x35 next cycle, `resp_valid`=1 with `resp_id`=2 and `resp_data`=`m_result` exactly LATENCY+2 cycles after the handshake, `issue_count`=1.
- All four requesters valid continuously for 8 cycles. Required: grant order 0,1,2,3,0,1,2,3; eight consecutive `resp` pulses with ids in the same order; `issue_count`=8.
- `cfg_enable`=0b1010 with all valid. Required: grants alternate 1,3,1,3; requesters 0 and 2 never see `req_ready`.
- Gapped traffic: requester 1 issues, idle cycle, requester 3 issues. Required: a `resp_valid` pattern of 1,0,1; `resp_id`/`resp_data` hold their values through the idle cycle.
- Reset mid-flight: issue 3 operands, then pulse `system1000_rstn` low for a fraction of a cycle before any result returns. Required: all outputs are 0 immediately, no `resp_valid` is ever produced for those operands, and the next grant goes to index 0.
- Counter wrap: force 65536 accepted transfers. Required: `issue_count` reads 0 afterwards.
